// File: rtl/zombie_pkg.sv
// ============================================================================
// Module   : zombie_pkg
// Desc     : Shared constants, spawn table and FSM encoding for the zombies.
// Revision : 1.0
// ============================================================================
`default_nettype none

package zombie_pkg;

    localparam logic [1:0] FACE_UP    = 2'b00;
    localparam logic [1:0] FACE_RIGHT = 2'b01;
    localparam logic [1:0] FACE_DOWN  = 2'b10;
    localparam logic [1:0] FACE_LEFT  = 2'b11;

    localparam int SPRITE_SIZE = 32;
    localparam int SCREEN_W    = 640;
    localparam int SCREEN_H    = 480;

    localparam logic [9:0] PARK_X = 10'(SCREEN_W);
    localparam logic [9:0] PARK_Y = 10'(SCREEN_H);
    localparam logic [9:0] MAX_X  = 10'(SCREEN_W - SPRITE_SIZE);
    localparam logic [9:0] MAX_Y  = 10'(SCREEN_H - SPRITE_SIZE);

    localparam logic [2:0][9:0] SPAWN_X = {10'd304, 10'd576, 10'd32};
    localparam logic [2:0][9:0] SPAWN_Y = {10'd416, 10'd32,  10'd32};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        UPD0 = 2'd1,
        UPD1 = 2'd2,
        UPD2 = 2'd3
    } state_t;

    function automatic logic [10:0] abs11(input logic signed [10:0] v);
        return v[10] ? $unsigned(-v) : $unsigned(v);
    endfunction

endpackage

`default_nettype wire

// File: rtl/zombie_step.sv
// ============================================================================
// Module   : zombie_step
// Desc     : Combinational single-zombie chase step: axis pick, face, clamp.
// Revision : 1.0
// ============================================================================
`default_nettype none

module zombie_step
    import zombie_pkg::*;
#(
    parameter int STEP = 2
) (
    input  logic [9:0] pos_x,
    input  logic [9:0] pos_y,
    input  logic [1:0] face,
    input  logic [9:0] player_x,
    input  logic [9:0] player_y,
    output logic [9:0] next_x,
    output logic [9:0] next_y,
    output logic [1:0] next_face
);

    localparam logic [10:0] C_STEP = 11'(STEP);

    logic signed [10:0] w_dx;
    logic signed [10:0] w_dy;
    logic [10:0]        w_adx;
    logic [10:0]        w_ady;
    logic [10:0]        w_mv;
    logic signed [11:0] w_sum_x;
    logic signed [11:0] w_sum_y;

    assign w_dx  = $signed({1'b0, player_x}) - $signed({1'b0, pos_x});
    assign w_dy  = $signed({1'b0, player_y}) - $signed({1'b0, pos_y});
    assign w_adx = abs11(w_dx);
    assign w_ady = abs11(w_dy);

    always_comb begin
        w_mv      = 11'd0;
        w_sum_x   = $signed({2'b00, pos_x});
        w_sum_y   = $signed({2'b00, pos_y});
        next_face = face;
        // A tie on nonzero distances resolves to the X axis.
        if ((w_adx >= w_ady) && (w_dx != 11'sd0)) begin
            w_mv = (w_adx < C_STEP) ? w_adx : C_STEP;
            if (!w_dx[10]) begin
                w_sum_x   = w_sum_x + $signed({1'b0, w_mv});
                next_face = FACE_RIGHT;
            end else begin
                w_sum_x   = w_sum_x - $signed({1'b0, w_mv});
                next_face = FACE_LEFT;
            end
        end else if (w_dy != 11'sd0) begin
            w_mv = (w_ady < C_STEP) ? w_ady : C_STEP;
            if (!w_dy[10]) begin
                w_sum_y   = w_sum_y + $signed({1'b0, w_mv});
                next_face = FACE_DOWN;
            end else begin
                w_sum_y   = w_sum_y - $signed({1'b0, w_mv});
                next_face = FACE_UP;
            end
        end

        if (w_sum_x < 12'sd0)
            next_x = 10'd0;
        else if (w_sum_x > $signed({2'b00, MAX_X}))
            next_x = MAX_X;
        else
            next_x = w_sum_x[9:0];

        if (w_sum_y < 12'sd0)
            next_y = 10'd0;
        else if (w_sum_y > $signed({2'b00, MAX_Y}))
            next_y = MAX_Y;
        else
            next_y = w_sum_y[9:0];
    end

endmodule

`default_nettype wire

// File: rtl/zombie_controller.sv
// ============================================================================
// Module   : zombie_controller
// Desc     : Per-frame chase, kill/park and respawn of three zombies.
//            Define ZOMBIE_PLAYER_HIT_EN to add the player_hit output.
// Revision : 1.0
// ============================================================================
`default_nettype none

module zombie_controller
    import zombie_pkg::*;
#(
    parameter int STEP           = 2,
    parameter int RESPAWN_FRAMES = 120
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       frame_clk,
    input  logic [9:0] PlayerX,
    input  logic [9:0] PlayerY,
    input  logic [2:0] kill,
`ifdef ZOMBIE_PLAYER_HIT_EN
    output logic       player_hit,
`endif
    output logic [9:0] Zombie0X,
    output logic [9:0] Zombie0Y,
    output logic [9:0] Zombie1X,
    output logic [9:0] Zombie1Y,
    output logic [9:0] Zombie2X,
    output logic [9:0] Zombie2Y,
    output logic [1:0] Zombie0Face,
    output logic [1:0] Zombie1Face,
    output logic [1:0] Zombie2Face,
    output logic [2:0] zombie_alive
);

    localparam logic [7:0] C_RELOAD = 8'(RESPAWN_FRAMES - 1);

    state_t     r_state;
    state_t     w_state_next;
    logic       r_fc_q;
    logic       w_tick;
    logic [9:0] r_x    [3];
    logic [9:0] r_y    [3];
    logic [1:0] r_face [3];
    logic [7:0] r_cnt  [3];
    logic [2:0] r_alive;

    logic [1:0] w_sel;
    logic [2:0] w_upd;
    logic [9:0] w_cur_x;
    logic [9:0] w_cur_y;
    logic [1:0] w_cur_face;
    logic [9:0] w_nx;
    logic [9:0] w_ny;
    logic [1:0] w_nface;

    assign w_tick = frame_clk & ~r_fc_q;

    always_ff @(posedge Clk) begin
        if (Reset)
            r_state <= IDLE;
        else
            r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        w_sel        = 2'd0;
        w_upd        = 3'b000;
        case (r_state)
            IDLE: if (w_tick) w_state_next = UPD0;
            UPD0: begin w_state_next = UPD1; w_sel = 2'd0; w_upd = 3'b001; end
            UPD1: begin w_state_next = UPD2; w_sel = 2'd1; w_upd = 3'b010; end
            UPD2: begin w_state_next = IDLE; w_sel = 2'd2; w_upd = 3'b100; end
            default: w_state_next = IDLE;
        endcase
    end

    always_comb begin
        w_cur_x    = r_x[0];
        w_cur_y    = r_y[0];
        w_cur_face = r_face[0];
        case (w_sel)
            2'd1: begin w_cur_x = r_x[1]; w_cur_y = r_y[1]; w_cur_face = r_face[1]; end
            2'd2: begin w_cur_x = r_x[2]; w_cur_y = r_y[2]; w_cur_face = r_face[2]; end
            default: ;
        endcase
    end

    zombie_step #(
        .STEP      (STEP)
    ) u_step (
        .pos_x     (w_cur_x),
        .pos_y     (w_cur_y),
        .face      (w_cur_face),
        .player_x  (PlayerX),
        .player_y  (PlayerY),
        .next_x    (w_nx),
        .next_y    (w_ny),
        .next_face (w_nface)
    );

    // Kill overrides the move/respawn slot of the same zombie.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_fc_q  <= 1'b0;
            r_alive <= 3'b111;
            for (int k = 0; k < 3; k++) begin
                r_x[k]    <= SPAWN_X[k];
                r_y[k]    <= SPAWN_Y[k];
                r_face[k] <= FACE_DOWN;
                r_cnt[k]  <= 8'd0;
            end
        end else begin
            r_fc_q <= frame_clk;
            for (int k = 0; k < 3; k++) begin
                if (kill[k]) begin
                    r_alive[k] <= 1'b0;
                    r_x[k]     <= PARK_X;
                    r_y[k]     <= PARK_Y;
                    r_cnt[k]   <= C_RELOAD;
                end else if (w_upd[k]) begin
                    if (r_alive[k]) begin
                        r_x[k]    <= w_nx;
                        r_y[k]    <= w_ny;
                        r_face[k] <= w_nface;
                    end else if (r_cnt[k] == 8'd0) begin
                        r_alive[k] <= 1'b1;
                        r_x[k]     <= SPAWN_X[k];
                        r_y[k]     <= SPAWN_Y[k];
                        r_face[k]  <= FACE_DOWN;
                    end else begin
                        r_cnt[k] <= r_cnt[k] - 8'd1;
                    end
                end
            end
        end
    end

`ifdef ZOMBIE_PLAYER_HIT_EN
    logic        r_hit;
    logic [10:0] w_hdx;
    logic [10:0] w_hdy;

    assign w_hdx = abs11($signed({1'b0, w_nx}) - $signed({1'b0, PlayerX}));
    assign w_hdy = abs11($signed({1'b0, w_ny}) - $signed({1'b0, PlayerY}));

    always_ff @(posedge Clk) begin
        if (Reset)
            r_hit <= 1'b0;
        else
            r_hit <= (w_upd != 3'b000) && r_alive[w_sel] && !kill[w_sel] &&
                     (w_hdx < 11'(SPRITE_SIZE)) && (w_hdy < 11'(SPRITE_SIZE));
    end

    assign player_hit = r_hit;
`endif

    assign Zombie0X     = r_x[0];
    assign Zombie0Y     = r_y[0];
    assign Zombie1X     = r_x[1];
    assign Zombie1Y     = r_y[1];
    assign Zombie2X     = r_x[2];
    assign Zombie2Y     = r_y[2];
    assign Zombie0Face  = r_face[0];
    assign Zombie1Face  = r_face[1];
    assign Zombie2Face  = r_face[2];
    assign zombie_alive = r_alive;

endmodule

`default_nettype wire
